seed_sweep_ctrl: RTL and testbench

//  Hardware sequencer that sweeps the two parallel datapath lanes across a table of seeds.
//  Per seed it performs: fetch seed, clear lanes, load inhibitor, start, wait for iteration limit, report result.

---
 rtl/seed_sweep_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_seed_sweep_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seed_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// seed_sweep_ctrl
//   Standalone sequencer that sweeps the two datapath lanes across a seed
//   table. For every seed it fetches the seed, clears both lanes, loads the
//   inhibitor select, starts the lanes, waits for the iteration limit (or a
//   cycle timeout) and hands the captured lane result to the sink.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   i_go, i_abort         start sweep (IDLE only) / synchronous abort to IDLE
//   o_busy, o_sweep_done  activity flag, 1-cycle end-of-sweep pulse
//   o_seed_rd/o_seed_addr seed memory read strobe and address
//   i_seed_data           seed memory data, valid one cycle after o_seed_rd
//   o_dp_*                lane controls: clear (active-low), inhibitor load,
//                         inhibitor select, start, seed {lane2, lane1}
//   i_iteration_number    lane 1 iteration count
//   i_steady_state1/2     lane steady flags
//   i_network_state1/2    lane network states
//   o_res_* / i_res_ready result record with valid/ready handshake
// ---------------------------------------------------------------------------
module seed_sweep_ctrl #(
   parameter int RULES      = 8,
   parameter int LOG_RULES  = 3,
   parameter int LOG_ITER   = 8,
   parameter int ITER_LIMIT = 8,
   parameter int NUM_SEEDS  = 3,
   parameter int LOG_SEEDS  = 10,
   parameter int INHIBITOR  = 0,
   parameter int TIMEOUT    = 4096
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_go,
   input  logic                 i_abort,
   output logic                 o_busy,
   output logic                 o_sweep_done,
   output logic                 o_seed_rd,
   output logic [LOG_SEEDS-1:0] o_seed_addr,
   input  logic [127:0]         i_seed_data,
   output logic                 o_dp_rst_n,
   output logic                 o_dp_ld_inhibitor,
   output logic [LOG_RULES-1:0] o_dp_sel_inhibitor,
   output logic                 o_dp_start,
   output logic [127:0]         o_dp_seed,
   input  logic [LOG_ITER-1:0]  i_iteration_number,
   input  logic                 i_steady_state1,
   input  logic                 i_steady_state2,
   input  logic [RULES-1:0]     i_network_state1,
   input  logic [RULES-1:0]     i_network_state2,
   output logic                 o_res_valid,
   input  logic                 i_res_ready,
   output logic [LOG_SEEDS-1:0] o_res_idx,
   output logic [RULES-1:0]     o_res_state1,
   output logic [RULES-1:0]     o_res_state2,
   output logic                 o_res_ss1,
   output logic                 o_res_ss2,
   output logic                 o_res_timeout
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_LOAD, S_CLR0, S_CLR1, S_INHIB,
      S_GAP, S_START, S_RUN, S_REPORT, S_DONE
   } state_t;

   state_t               r_state;
   state_t               w_state_next;
   logic [LOG_SEEDS-1:0] r_idx;
   logic [CNT_W-1:0]     r_cnt;
   logic [127:0]         r_dp_seed;
   logic [LOG_SEEDS-1:0] r_res_idx;
   logic [RULES-1:0]     r_res_state1;
   logic [RULES-1:0]     r_res_state2;
   logic                 r_res_ss1;
   logic                 r_res_ss2;
   logic                 r_res_timeout;

   logic w_iter_hit;
   logic w_tmo_hit;
   logic w_run_exit;
   logic w_last_seed;

   // The lane's iteration count may still hold the previous run's value in
   // the first RUN cycle, so the compare is masked while the counter is 0.
   assign w_iter_hit  = (r_cnt != '0) && (i_iteration_number >= LOG_ITER'(ITER_LIMIT));
   assign w_tmo_hit   = (r_cnt == CNT_W'(TIMEOUT - 1));
   assign w_run_exit  = w_iter_hit || w_tmo_hit;
   assign w_last_seed = (r_idx == LOG_SEEDS'(NUM_SEEDS - 1));

   assign o_seed_addr        = r_idx;
   assign o_dp_sel_inhibitor = ~LOG_RULES'(INHIBITOR);
   assign o_dp_seed          = r_dp_seed;
   assign o_res_idx          = r_res_idx;
   assign o_res_state1       = r_res_state1;
   assign o_res_state2       = r_res_state2;
   assign o_res_ss1          = r_res_ss1;
   assign o_res_ss2          = r_res_ss2;
   assign o_res_timeout      = r_res_timeout;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state and Moore outputs; outputs depend on r_state only, so an
   // asynchronous reset drives them to idle values immediately.
   always_comb begin
      w_state_next      = r_state;
      o_busy            = (r_state != S_IDLE);
      o_sweep_done      = 1'b0;
      o_seed_rd         = 1'b0;
      o_dp_rst_n        = 1'b0;
      o_dp_ld_inhibitor = 1'b0;
      o_dp_start        = 1'b0;
      o_res_valid       = 1'b0;
      case (r_state)
         S_IDLE:  if (i_go) w_state_next = S_FETCH;
         S_FETCH: begin
            o_seed_rd    = 1'b1;
            w_state_next = S_LOAD;
         end
         S_LOAD:  w_state_next = S_CLR0;
         S_CLR0:  w_state_next = S_CLR1;
         S_CLR1:  w_state_next = S_INHIB;
         S_INHIB: begin
            o_dp_rst_n        = 1'b1;
            o_dp_ld_inhibitor = 1'b1;
            w_state_next      = S_GAP;
         end
         S_GAP: begin
            o_dp_rst_n   = 1'b1;
            w_state_next = S_START;
         end
         S_START: begin
            o_dp_rst_n   = 1'b1;
            o_dp_start   = 1'b1;
            w_state_next = S_RUN;
         end
         S_RUN: begin
            o_dp_rst_n = 1'b1;
            if (w_run_exit) w_state_next = S_REPORT;
         end
         S_REPORT: begin
            o_dp_rst_n  = 1'b1;
            o_res_valid = 1'b1;
            if (i_res_ready) w_state_next = w_last_seed ? S_DONE : S_FETCH;
         end
         S_DONE: begin
            o_sweep_done = 1'b1;
            w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
      if (i_abort) w_state_next = S_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx         <= '0;
         r_cnt         <= '0;
         r_dp_seed     <= '0;
         r_res_idx     <= '0;
         r_res_state1  <= '0;
         r_res_state2  <= '0;
         r_res_ss1     <= 1'b0;
         r_res_ss2     <= 1'b0;
         r_res_timeout <= 1'b0;
      end else if (i_abort) begin
         r_idx <= '0;
         r_cnt <= '0;
      end else begin
         case (r_state)
            S_LOAD:  r_dp_seed <= i_seed_data;
            S_START: r_cnt <= '0;
            S_RUN: begin
               r_cnt <= r_cnt + CNT_W'(1);
               if (w_run_exit) begin
                  r_res_idx     <= r_idx;
                  r_res_state1  <= i_network_state1;
                  r_res_state2  <= i_network_state2;
                  r_res_ss1     <= i_steady_state1;
                  r_res_ss2     <= i_steady_state2;
                  // Reaching the limit on the final timeout cycle still
                  // counts as a normal completion.
                  r_res_timeout <= ~w_iter_hit;
               end
            end
            S_REPORT: if (i_res_ready && !w_last_seed) r_idx <= r_idx + LOG_SEEDS'(1);
            S_DONE:   r_idx <= '0;
            default:  ;
         endcase
      end
   end

endmodule

// File: tb/tb_seed_sweep_ctrl.sv
module tb_seed_sweep_ctrl;

   localparam int NS  = 3;
   localparam int IL  = 8;
   localparam int TO  = 16;
   localparam int STUCK = 99;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         i_go = 1'b0, i_abort = 1'b0;
   logic         o_busy, o_sweep_done, o_seed_rd;
   logic [9:0]   o_seed_addr;
   logic [127:0] i_seed_data = '0;
   logic         o_dp_rst_n, o_dp_ld_inhibitor, o_dp_start;
   logic [2:0]   o_dp_sel_inhibitor;
   logic [127:0] o_dp_seed;
   logic [7:0]   i_iteration_number = '0;
   logic         i_steady_state1 = 1'b0, i_steady_state2 = 1'b0;
   logic [7:0]   i_network_state1 = '0, i_network_state2 = '0;
   logic         o_res_valid, i_res_ready = 1'b0;
   logic [9:0]   o_res_idx;
   logic [7:0]   o_res_state1, o_res_state2;
   logic         o_res_ss1, o_res_ss2, o_res_timeout;

   always #5 clk = ~clk;

   seed_sweep_ctrl #(
      .RULES(8), .LOG_RULES(3), .LOG_ITER(8), .ITER_LIMIT(IL),
      .NUM_SEEDS(NS), .LOG_SEEDS(10), .INHIBITOR(0), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst), .i_go(i_go), .i_abort(i_abort),
      .o_busy(o_busy), .o_sweep_done(o_sweep_done),
      .o_seed_rd(o_seed_rd), .o_seed_addr(o_seed_addr), .i_seed_data(i_seed_data),
      .o_dp_rst_n(o_dp_rst_n), .o_dp_ld_inhibitor(o_dp_ld_inhibitor),
      .o_dp_sel_inhibitor(o_dp_sel_inhibitor), .o_dp_start(o_dp_start),
      .o_dp_seed(o_dp_seed), .i_iteration_number(i_iteration_number),
      .i_steady_state1(i_steady_state1), .i_steady_state2(i_steady_state2),
      .i_network_state1(i_network_state1), .i_network_state2(i_network_state2),
      .o_res_valid(o_res_valid), .i_res_ready(i_res_ready), .o_res_idx(o_res_idx),
      .o_res_state1(o_res_state1), .o_res_state2(o_res_state2),
      .o_res_ss1(o_res_ss1), .o_res_ss2(o_res_ss2), .o_res_timeout(o_res_timeout)
   );

   // reference model state
   logic [127:0] mem [0:1023];
   int           plan [NS];          // RUN cycle from which the lane reports >= limit
   int           n_chk = 0, n_err = 0;
   int           rc = 1000, exp_idx = 0, h_cur = 0, hold_cnt = 0;
   int           n_results = 0, n_done = 0;
   bit           start_last = 0, rd_last = 0, rv_last = 0, acc_last = 0, done_last = 0;
   logic [9:0]   rd_addr_last = '0;
   logic [29:0]  held = '0;
   logic [7:0]   n1_log [32];
   logic [7:0]   n2_log [32];
   logic [1:0]   ss_log [32];

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic new_mem();
      for (int i = 0; i < NS; i++) mem[10'(i)] = rand128();
   endtask

   task automatic model_reset();
      exp_idx = 0; rv_last = 0; acc_last = 0; done_last = 0; hold_cnt = 0;
   endtask

   // One clock: at the falling edge, drive the memory/lane/sink inputs for
   // this cycle and check the DUT against the model.
   task automatic tick();
      int  jx, je;
      bit  tmo, accepted;
      @(negedge clk);
      if (start_last) rc = 0; else if (rc < 100000) rc++;
      start_last = o_dp_start;
      i_seed_data = rd_last ? mem[rd_addr_last] : rand128();
      rd_last = o_seed_rd;
      rd_addr_last = o_seed_addr;
      // lane: iteration count stays below the limit until RUN cycle h_cur
      if (rc >= h_cur) i_iteration_number = 8'(IL + $urandom_range(0, 255 - IL));
      else             i_iteration_number = 8'($urandom_range(0, IL - 1));
      i_network_state1 = 8'($urandom);
      i_network_state2 = 8'($urandom);
      i_steady_state1  = 1'($urandom);
      i_steady_state2  = 1'($urandom);
      if (rc < 32) begin
         n1_log[rc] = i_network_state1;
         n2_log[rc] = i_network_state2;
         ss_log[rc] = {i_steady_state1, i_steady_state2};
      end
      if (o_dp_start) begin
         check_eq("dp_seed", o_dp_seed, mem[10'(exp_idx)]);
         h_cur = plan[exp_idx];
      end
      if (o_res_valid && !rv_last) begin
         jx  = (h_cur < 1) ? 1 : h_cur;
         tmo = (jx > TO - 1);
         je  = tmo ? TO - 1 : jx;
         check_eq("res_idx", 128'(o_res_idx), 128'(exp_idx));
         check_eq("res_timeout", 128'(o_res_timeout), 128'(tmo));
         check_eq("run_len", 128'(rc), 128'(je + 1));
         check_eq("res_state1", 128'(o_res_state1), 128'(n1_log[je]));
         check_eq("res_state2", 128'(o_res_state2), 128'(n2_log[je]));
         check_eq("res_ss", 128'({o_res_ss1, o_res_ss2}), 128'(ss_log[je]));
      end
      if (o_res_valid && rv_last && !acc_last)
         check_eq("res_hold", 128'({o_res_idx, o_res_state1, o_res_state2,
                                    o_res_ss1, o_res_ss2, o_res_timeout}), 128'(held));
      if (o_res_valid && hold_cnt > 0) begin
         i_res_ready = 1'b0;
         hold_cnt--;
      end else begin
         i_res_ready = ($urandom_range(0, 3) != 0);
      end
      accepted = o_res_valid && i_res_ready;
      if (accepted) begin
         exp_idx++;
         n_results++;
      end
      if (done_last) check_eq("busy_after_done", 128'(o_busy), 128'(0));
      if (o_sweep_done) begin
         n_done++;
         check_eq("done_after_last", 128'(exp_idx), 128'(NS));
         exp_idx = 0;
      end
      done_last = o_sweep_done;
      rv_last   = o_res_valid;
      acc_last  = accepted;
      held = {o_res_idx, o_res_state1, o_res_state2, o_res_ss1, o_res_ss2, o_res_timeout};
   endtask

   // Run until the sweep_done count reaches want, pulsing go while busy.
   task automatic wait_sweep(input int want);
      int lim = 0;
      while (n_done < want && lim < 2000) begin
         tick();
         i_go = (o_busy && !o_sweep_done) ? 1'($urandom) : 1'b0;
         lim++;
      end
      i_go = 1'b0;
      check_eq("sweep_done_count", 128'(n_done), 128'(want));
      tick();
   endtask

   initial begin
      int lim;
      int rv_seen, busy_seen;
      repeat (3) tick();
      check_eq("rst_busy", 128'(o_busy), 128'(0));
      check_eq("rst_dp_rst_n", 128'(o_dp_rst_n), 128'(0));
      check_eq("rst_seed_rd", 128'({o_seed_rd, o_seed_addr}), 128'(0));
      check_eq("rst_dp_seed", o_dp_seed, 128'(0));
      check_eq("rst_res", 128'({o_res_valid, o_res_idx, o_res_timeout, o_sweep_done}), 128'(0));
      rst = 1'b0;
      model_reset();
      tick();

      // sweep 1: strobe timing, a normal run, a timeout and a stale-first-cycle run
      new_mem();
      plan = '{5, STUCK, 0};
      hold_cnt = 10;
      n_results = 0; n_done = 0;
      i_go = 1'b1;
      tick();
      i_go = 1'b0;
      check_eq("c1_seed_rd", 128'({o_seed_rd, o_seed_addr, o_busy}), 128'({1'b1, 10'd0, 1'b1}));
      tick();
      check_eq("c2_seed_rd", 128'(o_seed_rd), 128'(0));
      tick();
      check_eq("c3_rst_n", 128'(o_dp_rst_n), 128'(0));
      check_eq("c3_dp_seed", o_dp_seed, mem[0]);
      tick();
      check_eq("c4_rst_n", 128'(o_dp_rst_n), 128'(0));
      tick();
      check_eq("c5_ld_inh", 128'({o_dp_ld_inhibitor, o_dp_rst_n, o_dp_start}), 128'(3'b110));
      check_eq("sel_inhibitor", 128'(o_dp_sel_inhibitor), 128'(3'b111));
      tick();
      check_eq("c6_gap", 128'({o_dp_ld_inhibitor, o_dp_start}), 128'(0));
      tick();
      check_eq("c7_start", 128'(o_dp_start), 128'(1));
      wait_sweep(1);
      check_eq("sweep1_results", 128'(n_results), 128'(NS));

      // sweep 2: random lane behaviour
      new_mem();
      for (int i = 0; i < NS; i++) plan[i] = $urandom_range(0, 20);
      n_results = 0; n_done = 0;
      i_go = 1'b1;
      tick();
      i_go = 1'b0;
      wait_sweep(1);
      check_eq("sweep2_results", 128'(n_results), 128'(NS));

      // abort during RUN of seed 1
      new_mem();
      plan = '{3, STUCK, 2};
      n_results = 0; n_done = 0;
      i_go = 1'b1;
      tick();
      i_go = 1'b0;
      lim = 0;
      while (!(exp_idx == 1 && o_dp_start) && lim < 200) begin
         tick();
         lim++;
      end
      check_eq("abort_reach_seed1", 128'(exp_idx), 128'(1));
      repeat (3) tick();
      i_abort = 1'b1;
      tick();
      i_abort = 1'b0;
      model_reset();
      check_eq("abort_idle", 128'({o_busy, o_res_valid, o_dp_rst_n, o_seed_addr}), 128'(0));
      repeat (5) tick();
      check_eq("abort_no_done", 128'(n_done), 128'(0));
      i_go = 1'b1; i_abort = 1'b1;
      tick();
      i_go = 1'b0; i_abort = 1'b0;
      check_eq("go_abort_idle", 128'(o_busy), 128'(0));
      n_results = 0;
      i_go = 1'b1;
      tick();
      i_go = 1'b0;
      check_eq("restart_idx0", 128'({o_seed_rd, o_seed_addr}), 128'({1'b1, 10'd0}));
      wait_sweep(1);
      check_eq("restart_results", 128'(n_results), 128'(NS));

      // asynchronous reset in the middle of a run
      new_mem();
      plan = '{STUCK, STUCK, STUCK};
      n_done = 0;
      i_go = 1'b1;
      tick();
      i_go = 1'b0;
      lim = 0;
      while (!o_dp_start && lim < 50) begin
         tick();
         lim++;
      end
      repeat (4) tick();
      #2 rst = 1'b1;
      #1;
      check_eq("arst_ctrl", 128'({o_busy, o_dp_rst_n, o_dp_start, o_dp_ld_inhibitor,
                                  o_seed_rd, o_res_valid, o_sweep_done}), 128'(0));
      check_eq("arst_dp_seed", o_dp_seed, 128'(0));
      i_go = 1'b1;
      tick();
      i_go = 1'b0;
      rst = 1'b0;
      model_reset();
      rv_seen = 0; busy_seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         rv_seen += int'(o_res_valid);
         busy_seen += int'(o_busy);
      end
      check_eq("post_rst_quiet", 128'({rv_seen, busy_seen}), 128'(0));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
